// File: rtl/stack_ram_responder_if.sv
// Request/response bundle between the stack-pointer unit (master) and the
// return-address stack RAM responder (slave).
//   Store_RAM_signal / Load_RAM_signal : push / pop request levels
//   Top_Stack                          : stack pointer, low bits index the array
//   Return_Addr_in                     : address pushed on JAL
//   Return_Addr_out / Return_Valid     : popped address and its one-cycle strobe
//   Busy                               : responder is mid-access, requests ignored
//   Overflow / Underflow / Conflict    : sticky error flags
interface stack_ram_responder_if #(
    parameter int DATA_W = 32
);
    logic              Store_RAM_signal;
    logic              Load_RAM_signal;
    logic [31:0]       Top_Stack;
    logic [DATA_W-1:0] Return_Addr_in;
    logic [DATA_W-1:0] Return_Addr_out;
    logic              Return_Valid;
    logic              Busy;
    logic              Overflow;
    logic              Underflow;
    logic              Conflict;

    modport master (
        output Store_RAM_signal, Load_RAM_signal, Top_Stack, Return_Addr_in,
        input  Return_Addr_out, Return_Valid, Busy, Overflow, Underflow, Conflict
    );

    modport slave (
        input  Store_RAM_signal, Load_RAM_signal, Top_Stack, Return_Addr_in,
        output Return_Addr_out, Return_Valid, Busy, Overflow, Underflow, Conflict
    );
endinterface

// File: rtl/stack_ram_responder.sv
// Return-address stack RAM responder. Pushes write Return_Addr_in into the
// array at Top_Stack[ADDR_W-1:0]; pops read that entry back and strobe it
// out with Return_Valid. Occupancy is tracked to flag overflow / underflow.
// Ports:
//   clk   : system clock
//   rst_n : asynchronous active-low reset
//   bus   : stack_ram_responder_if.slave (requests in, response/flags out)
module stack_ram_responder #(
    parameter int ADDR_W = 4,
    parameter int DEPTH  = 16,
    parameter int DATA_W = 32
) (
    input  logic                   clk,
    input  logic                   rst_n,
    stack_ram_responder_if.slave   bus
);

    if (DEPTH != (1 << ADDR_W)) begin : g_bad_depth
        $error("stack_ram_responder: DEPTH must equal 2**ADDR_W");
    end

    localparam logic [ADDR_W:0] FULL = (ADDR_W+1)'(DEPTH);

    typedef enum logic [1:0] {IDLE, WRITE, READ, RESP} state_t;

    state_t            state;
    logic [ADDR_W:0]   count;
    logic [ADDR_W-1:0] idx_q;
    logic [DATA_W-1:0] data_q;
    logic [DATA_W-1:0] mem [DEPTH];

    // Upper pointer bits only matter to the stack-pointer unit.
    logic unused_top;
    assign unused_top = ^bus.Top_Stack[31:ADDR_W];

    // Array has no reset; written only from the WRITE state.
    always_ff @(posedge clk) begin
        if (state == WRITE)
            mem[idx_q] <= data_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state               <= IDLE;
            count               <= '0;
            idx_q               <= '0;
            data_q              <= '0;
            bus.Return_Addr_out <= '0;
            bus.Return_Valid    <= 1'b0;
            bus.Busy            <= 1'b0;
            bus.Overflow        <= 1'b0;
            bus.Underflow       <= 1'b0;
            bus.Conflict        <= 1'b0;
        end else begin
            bus.Return_Valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.Store_RAM_signal && bus.Load_RAM_signal) begin
                        bus.Conflict <= 1'b1;
                    end else if (bus.Store_RAM_signal) begin
                        if (count == FULL) begin
                            bus.Overflow <= 1'b1;
                        end else begin
                            idx_q    <= bus.Top_Stack[ADDR_W-1:0];
                            data_q   <= bus.Return_Addr_in;
                            state    <= WRITE;
                            bus.Busy <= 1'b1;
                        end
                    end else if (bus.Load_RAM_signal) begin
                        if (count == '0) begin
                            // Empty pop still answers (with zero) so the
                            // fetch unit waiting on Return_Valid never stalls.
                            bus.Underflow       <= 1'b1;
                            bus.Return_Addr_out <= '0;
                            state               <= RESP;
                        end else begin
                            idx_q <= bus.Top_Stack[ADDR_W-1:0];
                            state <= READ;
                        end
                        bus.Busy <= 1'b1;
                    end
                end
                WRITE: begin
                    count    <= count + 1'b1;
                    state    <= IDLE;
                    bus.Busy <= 1'b0;
                end
                READ: begin
                    bus.Return_Addr_out <= mem[idx_q];
                    count               <= count - 1'b1;
                    state               <= RESP;
                end
                RESP: begin
                    // Strobe is registered off RESP, so it lands in the cycle
                    // after RESP while the data register is already stable.
                    bus.Return_Valid <= 1'b1;
                    state            <= IDLE;
                    bus.Busy         <= 1'b0;
                end
                default: begin
                    state    <= IDLE;
                    bus.Busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_stack_ram_responder.sv
module tb_stack_ram_responder;

    logic clk;
    logic rst_n;

    stack_ram_responder_if #(.DATA_W(32)) bus ();

    stack_ram_responder #(.ADDR_W(4), .DEPTH(16), .DATA_W(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference model: plain array indexed by pointer, occupancy counter,
    // sticky flags, and the queue of responses the DUT owes us.
    logic [31:0] m_mem [16];
    bit          m_wr  [16];
    int          m_cnt = 0;
    bit          m_ovf = 0, m_unf = 0, m_cnf = 0;
    logic [31:0] exp_q [$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every Return_Valid strobe must match the next owed response.
    always @(negedge clk) begin
        if (bus.Return_Valid) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_valid: got data %h expected no strobe at %0t",
                         bus.Return_Addr_out, $time);
            end else begin
                chk("pop_data", bus.Return_Addr_out, exp_q.pop_front());
            end
        end
    end

    task automatic chk_reset_outputs();
        chk("rst_addr_out", bus.Return_Addr_out, 32'h0);
        chk("rst_valid", {31'b0, bus.Return_Valid}, 32'h0);
        chk("rst_busy", {31'b0, bus.Busy}, 32'h0);
        chk("rst_flags", {29'b0, bus.Overflow, bus.Underflow, bus.Conflict}, 32'h0);
    endtask

    task automatic wait_idle();
        int g = 0;
        while (bus.Busy && g < 20) begin
            @(negedge clk);
            g++;
        end
        if (g >= 20) begin
            checks++;
            errors++;
            $display("FAIL busy_timeout: Busy still %b expected 0 after %0d cycles", bus.Busy, g);
        end
    endtask

    task automatic op(input bit st, input bit ld, input logic [31:0] ts, input logic [31:0] d);
        int  idx;
        int  n;
        int  lat;
        bit  ebusy;
        idx   = int'(ts[3:0]);
        lat   = 0;
        ebusy = 0;
        wait_idle();
        @(negedge clk);
        bus.Store_RAM_signal = st;
        bus.Load_RAM_signal  = ld;
        bus.Top_Stack        = ts;
        bus.Return_Addr_in   = d;
        if (st && ld) begin
            m_cnf = 1;
        end else if (st) begin
            if (m_cnt == 16) m_ovf = 1;
            else begin
                m_mem[idx] = d;
                m_wr[idx]  = 1;
                m_cnt++;
                ebusy = 1;
            end
        end else if (ld) begin
            ebusy = 1;
            if (m_cnt == 0) begin
                m_unf = 1;
                exp_q.push_back(32'h0);
                lat = 2;
            end else begin
                exp_q.push_back(m_mem[idx]);
                m_cnt--;
                lat = 3;
            end
        end
        @(posedge clk);
        @(negedge clk);
        n = 1;
        chk("busy", {31'b0, bus.Busy}, {31'b0, ebusy});
        bus.Store_RAM_signal = 1'b0;
        bus.Load_RAM_signal  = 1'b0;
        if (lat > 0) begin
            while (!bus.Return_Valid && n < 8) begin
                @(negedge clk);
                n++;
            end
            chk("valid_latency", n, lat);
        end
        chk("overflow", {31'b0, bus.Overflow}, {31'b0, m_ovf});
        chk("underflow", {31'b0, bus.Underflow}, {31'b0, m_unf});
        chk("conflict", {31'b0, bus.Conflict}, {31'b0, m_cnf});
    endtask

    task automatic push(input logic [31:0] ts, input logic [31:0] d);
        op(1'b1, 1'b0, ts, d);
    endtask

    task automatic pop(input logic [31:0] ts);
        op(1'b0, 1'b1, ts, 32'h0);
    endtask

    initial begin
        int r;
        int idx;
        rst_n                = 1'b0;
        bus.Store_RAM_signal = 1'b0;
        bus.Load_RAM_signal  = 1'b0;
        bus.Top_Stack        = 32'h0;
        bus.Return_Addr_in   = 32'h0;
        for (int i = 0; i < 16; i++) m_wr[i] = 0;
        repeat (3) @(negedge clk);
        chk_reset_outputs();
        rst_n = 1'b1;

        // Pop from empty: zero response, Underflow.
        pop(32'd5);
        // Single push/pop round trip.
        push(32'd1, 32'h0000_0040);
        pop(32'd1);
        // Three deep, popped in reverse.
        push(32'd1, 32'hAAAA_0001);
        push(32'd2, 32'hAAAA_0002);
        push(32'd3, 32'hAAAA_0003);
        pop(32'd3);
        pop(32'd2);
        pop(32'd1);
        // Simultaneous requests.
        op(1'b1, 1'b1, 32'd7, 32'h1234_5678);
        // Pointer wrap: all-ones selects the last entry.
        push(32'hFFFF_FFFF, 32'h5A5A_F00F);
        pop(32'h0000_000F);
        // Fill, then one more push must be refused.
        for (int i = 0; i < 16; i++) push(i, 32'hC000_0000 | i);
        push(32'd0, 32'hDEAD_BEEF);
        pop(32'd0);
        for (int i = 1; i < 16; i++) pop(32'h0000_0100 | i);

        // Randomized mix against the model.
        for (int k = 0; k < 200; k++) begin
            r = $urandom_range(0, 99);
            if (r < 45) begin
                push(($urandom() & 32'hFFFF_FFF0) | $urandom_range(0, 15), $urandom());
            end else if (r < 90) begin
                idx = $urandom_range(0, 15);
                if (m_cnt > 0)
                    while (!m_wr[idx]) idx = $urandom_range(0, 15);
                pop(($urandom() & 32'hFFFF_FFF0) | idx);
            end else begin
                op(1'b1, 1'b1, $urandom(), $urandom());
            end
        end

        // Reset during READ aborts the pop with no strobe.
        wait_idle();
        if (m_cnt == 16) pop(32'd0);
        push(32'd9, 32'h0BAD_CAFE);
        wait_idle();
        @(negedge clk);
        bus.Load_RAM_signal = 1'b1;
        bus.Top_Stack       = 32'd9;
        @(posedge clk);
        @(negedge clk);
        bus.Load_RAM_signal = 1'b0;
        rst_n = 1'b0;
        #1;
        chk_reset_outputs();
        m_cnt = 0;
        m_ovf = 0;
        m_unf = 0;
        m_cnf = 0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        chk("post_reset_valid", {31'b0, bus.Return_Valid}, 32'h0);
        // Count really restarted at zero: an empty pop underflows.
        pop(32'd9);
        wait_idle();
        repeat (3) @(negedge clk);
        chk("queue_drained", exp_q.size(), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/stack_ram_responder.md
Name: stack_ram_responder

Overview:
- RAM-side responder for the return-address stack. Consumes the push/pop requests (Store_RAM_signal / Load_RAM_signal) and stack pointer issued by the stack-pointer unit on JAL / JS.
- On a push it writes the return address into an internal stack array; on a pop it reads the array and returns the address to the PC-select logic with a valid pulse.
- Tracks occupancy and flags overflow, underflow and conflicting requests.

Parameters:
- ADDR_W, 4, index width into the stack array (low ADDR_W bits of Top_Stack used).
- DEPTH, 16, number of entries; must equal 2**ADDR_W.
- DATA_W, 32, return-address width.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- Store_RAM_signal  input  1  push request (JAL); sampled in IDLE only.
- Load_RAM_signal  input  1  pop request (JS); sampled in IDLE only.
- Top_Stack  input  32  stack pointer for the access; bits [ADDR_W-1:0] index the array.
- Return_Addr_in  input  DATA_W  return address to store on push.
- Return_Addr_out  output  DATA_W  popped return address; valid only while Return_Valid=1.
- Return_Valid  output  1  one-cycle pulse, popped data present.
- Busy  output  1  high whenever FSM not in IDLE; requests ignored while high.
- Overflow  output  1  sticky: push attempted at full.
- Underflow  output  1  sticky: pop attempted at empty.
- Conflict  output  1  sticky: push and pop asserted in the same IDLE cycle.

Behaviour:
- Reset (rst_n=0, async): FSM=IDLE, occupancy count=0, Return_Addr_out=0, Return_Valid=0, Busy=0, Overflow=0, Underflow=0, Conflict=0. Array contents are not reset; reset mid-operation aborts any in-flight access and produces no Return_Valid.
- Occupancy count is ADDR_W+1 bits wide, range 0..DEPTH. Index = Top_Stack[ADDR_W-1:0]; upper bits ignored, so wrap-around is modulo DEPTH.
- FSM states: IDLE, WRITE, READ, RESP.
- IDLE, store=1, load=0:
  - count<DEPTH: latch index and data, go to WRITE.
  - count==DEPTH: set Overflow, no write, stay IDLE.
- IDLE, load=1, store=0:
  - count>0: latch index, go to READ.
  - count==0: set Underflow, go to RESP with Return_Addr_out=0, so the fetch unit never stalls.
- IDLE, both=1: set Conflict, no access, count unchanged, stay IDLE.
- WRITE (1 cycle): mem[index] <= data; count <= count+1; go to IDLE.
- READ (1 cycle): synchronous array read of mem[index] into the output register; count <= count-1; go to RESP.
- RESP (1 cycle): Return_Valid=1 with Return_Addr_out held stable; go to IDLE.
- Latency:
  - Push accepted at edge N: written at edge N+1; Busy high for 1 cycle.
  - Pop accepted at edge N: Return_Valid high in the cycle after edge N+2; Busy high for 2 cycles (READ, RESP).
  - Underflow pop: Return_Valid in the cycle after edge N+1.
- Return_Addr_out holds its last value after RESP; it is not cleared.
- Requests are levels. A request still high when the FSM returns to IDLE is treated as a new request. The requester must drop it after Busy is seen high.
- Sticky flags clear only on reset.
- Push then pop at the same Top_Stack index returns the pushed value. Write-before-read ordering is guaranteed by the FSM serialising accesses.

Test Plan:
- Push 0x0000_0040 at Top_Stack=1, then pop at Top_Stack=1 -> Return_Valid pulses once, 3 cycles after pop request sampled; Return_Addr_out=0x0000_0040; count back to 0.
- Push 0xAAAA_0001, 0xAAAA_0002, 0xAAAA_0003 at indices 1,2,3; pop at indices 3,2,1 -> outputs 0xAAAA_0003, 0xAAAA_0002, 0xAAAA_0001 in order; no flags set.
- 16 pushes, then a 17th push with Return_Addr_in=0xDEAD_BEEF -> Overflow=1; entry at the 17th index unchanged; count stays 16.
- Pop from empty after reset -> Underflow=1; Return_Valid pulses with Return_Addr_out=0x0000_0000.
- Store and Load both high in IDLE -> Conflict=1, Busy stays 0, count unchanged; Top_Stack=0xFFFF_FFFF push then pop returns data via index 15 (wrap).
- Drop rst_n during READ -> all outputs return to reset values immediately; no Return_Valid pulse follows.
